// File: rtl/dmem_uart_dumper.sv
// Streams a block of 32-bit RAM words out of a UART TX line as 8N1 bytes,
// little-endian, for read-back verification of programmed data RAM.
module dmem_uart_dumper #(
  parameter int CLK_HZ = 10_000_000,
  parameter int BAUD   = 128_000,
  parameter int ADDR_W = 14
) (
  input  logic              upg_clk_i,
  input  logic              upg_rst_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_adr_i,
  input  logic [ADDR_W-1:0] word_cnt_i,
  output logic [ADDR_W-1:0] ram_adr_o,
  input  logic [31:0]       ram_dat_i,
  output logic              tx_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int DW  = (DIV > 2) ? $clog2(DIV) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LATCH, S_SEND, S_NEXT, S_FIN
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [ADDR_W-1:0] rem_q, rem_d;
  logic [31:0]       word_q, word_d;
  logic [DW-1:0]     div_q, div_d;
  logic [3:0]        bit_q, bit_d;
  logic [1:0]        byte_q, byte_d;
  logic              tx_q, tx_d;
  logic              done_q, done_d;

  always_ff @(posedge upg_clk_i) begin
    if (upg_rst_i) begin
      state_q <= S_IDLE;
      adr_q   <= '0;
      rem_q   <= '0;
      word_q  <= '0;
      div_q   <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      rem_q   <= rem_d;
      word_q  <= word_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    rem_d   = rem_q;
    word_d  = word_q;
    div_d   = div_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    tx_d    = 1'b1;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        // done_q still high means FIN just ended; a start in that cycle is dropped
        if (start_i && !done_q) begin
          adr_d   = base_adr_i;
          rem_d   = word_cnt_i;
          state_d = (word_cnt_i == '0) ? S_FIN : S_FETCH;
        end
      end
      S_FETCH: state_d = S_LATCH;
      S_LATCH: begin
        word_d  = ram_dat_i;
        div_d   = '0;
        bit_d   = '0;
        byte_d  = '0;
        state_d = S_SEND;
      end
      S_SEND: begin
        // word shifts right once per data bit, so word_q[0] is always the next data bit
        if (bit_q == 4'd0)      tx_d = 1'b0;
        else if (bit_q == 4'd9) tx_d = 1'b1;
        else                    tx_d = word_q[0];
        if (div_q == DW'(DIV - 1)) begin
          div_d = '0;
          if (bit_q != 4'd0 && bit_q != 4'd9) word_d = {1'b0, word_q[31:1]};
          if (bit_q == 4'd9) begin
            bit_d = '0;
            if (byte_q == 2'd3) begin
              byte_d  = '0;
              state_d = S_NEXT;
            end else begin
              byte_d = byte_q + 2'd1;
            end
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      S_NEXT: begin
        adr_d   = adr_q + ADDR_W'(1);
        rem_d   = rem_q - ADDR_W'(1);
        state_d = (rem_q == ADDR_W'(1)) ? S_FIN : S_FETCH;
      end
      S_FIN: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign ram_adr_o = adr_q;
  assign tx_o      = tx_q;
  assign busy_o    = (state_q != S_IDLE);
  assign done_o    = done_q;

endmodule
